count_display: RTL
==================

COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the binary count input.
REQ-002 Parameter DIGITS, default 4: number of multiplexed 7-segment digits.
REQ-003 Parameter SCAN_DIV, default 100000: clock cycles each digit is driven (>= 2).
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 value_i  input  DATA_WIDTH  unsigned binary count to display (driven by the counter's count_o).
REQ-007 an_o  output  DIGITS  digit enables, active-low, at most one low.
REQ-008 seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 dp_o  output  1  decimal point, active-low; held 1 (off).
REQ-010 bcd_o  output  4*DIGITS  last converted BCD value; digit 0 (ones) in bits [3:0].
REQ-011 busy_o  output  1  high while a conversion is in progress.

Function
REQ-012 Conversion FSM SHALL have states IDLE, CONVERT, LOAD.
REQ-013 IDLE: if value_i differs from the last latched value, or the post-reset force flag is set, then latch value_i, clear BCD scratch and force flag, set iteration count to DATA_WIDTH, and go to CONVERT.
REQ-014 CONVERT (one bit per cycle, shift-add-3): add 3 to each scratch nibble >= 5, then shift {scratch, shift reg} left by one; decrement the count; go to LOAD after the DATA_WIDTH-th iteration.
REQ-015 LOAD: copy scratch to bcd_o, return to IDLE; total latency from the IDLE sample to the bcd_o update is DATA_WIDTH+2 cycles.
REQ-016 busy_o SHALL be 1 in CONVERT and LOAD, and 0 in IDLE.
REQ-017 value_i changes during CONVERT/LOAD are not sampled; the next IDLE cycle compares value_i against the latched value and restarts if they differ (intermediate values may be skipped).
REQ-018 Values >= 10^DIGITS SHALL display only the low DIGITS decimal digits (higher digits are dropped, no error flag).
REQ-019 Scan prescaler counts 0..SCAN_DIV-1 and wraps; on wrap the digit index increments 0..DIGITS-1 and wraps to 0.
REQ-020 an_o, seg_o registered: one cycle after the index changes, an_o has only bit[index] low, and seg_o shows the decoded nibble index of bcd_o.
REQ-021 Decode SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; nibbles >9 decode to 1111111.
REQ-022 Leading-zero blanking: digit i>0 SHALL be blanked (seg_o=1111111, an_o still low) when it and all higher digits are 0; digit 0 is never blanked.
REQ-023 bcd_o changing mid-scan SHALL take effect on the next registered seg_o update; the scan is not reset.

Reset
REQ-024 While rstn_i=0: state IDLE, bcd_o=0, latched value 0, force flag 1, busy_o=0, prescaler 0, index 0, an_o all 1, seg_o=1111111, dp_o=1.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion immediately; after release, value_i converts unconditionally (force flag).
REQ-026 First conversion after release SHALL complete DATA_WIDTH+2 cycles after the first IDLE edge, even if value_i=0.

Verification (DATA_WIDTH=8, DIGITS=4, SCAN_DIV=4)
REQ-027 Reset release with value_i=0 -> busy_o high for 10 cycles, bcd_o=0x0000; digit 0 shows 1000000 and digits 1-3 are blanked.
REQ-028 value_i 0->255 -> bcd_o=0x0255 after 10 cycles; over one 16-cycle scan, seg_o shows 0010010, 0010010, 0100100, then blank with an_o=0111.
REQ-029 value_i 7->8->9 on successive cycles while busy -> conversion of 7 completes; then 9 is converted (8 skipped); final bcd_o=0x0009.
REQ-030 value_i=100 held stable -> exactly one conversion; busy_o stays 0 afterward; bcd_o=0x0100; digit 2 shows 1111001 and digit 1 shows 1000000 (not blanked).
REQ-031 rstn_i pulsed low at CONVERT iteration 4 with value_i=42 -> outputs at reset values during the pulse; after release bcd_o=0x0042 after 10 cycles.
REQ-032 Continuous scan check -> an_o never has more than one bit low; the index advances every 4 cycles, in order 0,1,2,3,0.

Source files
------------

// File: rtl/count_display_if.sv
// Display-side bundle of count_display: count in, multiplexed 7-segment drive and BCD status out.
interface count_display_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIGITS     = 4
);
  logic [DATA_WIDTH-1:0] value;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dp;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;

  modport master (output value, input an, seg, dp, bcd, busy);
  modport slave  (input value, output an, seg, dp, bcd, busy);
endinterface

// File: rtl/count_display.sv
// Binary-to-BCD converter (shift-add-3) feeding a multiplexed active-low 7-segment scanner.
// bcd updates DATA_WIDTH+2 cycles after a new value is sampled in IDLE; no backpressure, changes while busy are skipped.
module count_display #(
  parameter int DATA_WIDTH = 8,
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 100000
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  count_display_if.slave disp
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] latched;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  force_cvt;
  logic [BW-1:0]         scratch;
  logic [BW-1:0]         adj;
  logic [BW-1:0]         bcd_r;
  logic [CW-1:0]         cnt;
  logic                  busy_r;

  logic [PW-1:0]         psc;
  logic [IW-1:0]         idx;
  logic [DIGITS-1:0]     an_r;
  logic [6:0]            seg_r;
  logic [DIGITS:0]       hi_zero;
  logic [3:0]            cur_nib;
  logic                  cur_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // CONVERT spends one extra cycle on the cnt==0 check, giving DATA_WIDTH+2 cycles of busy.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= IDLE;
      latched   <= '0;
      shreg     <= '0;
      force_cvt <= 1'b1;
      scratch   <= '0;
      cnt       <= '0;
      bcd_r     <= '0;
      busy_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (force_cvt || (disp.value != latched)) begin
            latched   <= disp.value;
            shreg     <= disp.value;
            scratch   <= '0;
            force_cvt <= 1'b0;
            cnt       <= CW'(DATA_WIDTH);
            busy_r    <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          if (cnt == '0) begin
            state <= LOAD;
          end else begin
            scratch <= {adj[BW-2:0], shreg[DATA_WIDTH-1]};
            shreg   <= shreg << 1;
            cnt     <= cnt - CW'(1);
          end
        end
        LOAD: begin
          bcd_r  <= scratch;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // hi_zero[i]: digit i and every digit above it are zero.
  always_comb begin
    hi_zero         = '0;
    hi_zero[DIGITS] = 1'b1;
    cur_nib         = 4'd0;
    cur_blank       = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hi_zero[i] = (bcd_r[4*i +: 4] == 4'd0) && hi_zero[i+1];
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = bcd_r[4*i +: 4];
        cur_blank = (i != 0) && hi_zero[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      psc   <= '0;
      idx   <= '0;
      an_r  <= '1;
      seg_r <= 7'b1111111;
    end else begin
      if (psc == PW'(SCAN_DIV - 1)) begin
        psc <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        psc <= psc + PW'(1);
      end
      an_r  <= ~(DIGITS'(1) << idx);
      seg_r <= cur_blank ? 7'b1111111 : seg_decode(cur_nib);
    end
  end

  assign disp.an   = an_r;
  assign disp.seg  = seg_r;
  assign disp.dp   = 1'b1;
  assign disp.bcd  = bcd_r;
  assign disp.busy = busy_r;

endmodule
